uart_hamming_rx: RTL
====================

Name: uart_hamming_rx

Overview:
Far-end receiver for the Hamming-protected UART link: it deserializes 8N1 frames produced by the existing transmit path. Each frame carries a Hamming(7,4) codeword in bits [6:0] and a zero pad in bit 7. The block corrects single-bit errors, recovers the 4-bit nibble and delivers it over a valid/ready handshake with status flags. It sits between the rx pad and the consumer logic, and replaces the separate receiver/decoder pair for link-partner use.

Parameters:
CLKS_PER_BIT, 16, clocks per UART bit; legal range 4 to 65535; the counter is sized with $clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
data_out  output  4  decoded, corrected nibble
data_valid  output  1  data_out, syndrome and corrected are valid
data_ready  input  1  consumer accepts when data_valid && data_ready
syndrome  output  3  Hamming syndrome of the delivered frame
corrected  output  1  syndrome != 0 (one bit was flipped)
pad_err  output  1  bit 7 of the delivered frame was 1
frame_err  output  1  one-cycle pulse; stop bit sampled low
overrun  output  1  one-cycle pulse; a frame completed while data_valid was held
busy  output  1  FSM is not in IDLE
state_out  output  3  FSM state encoding, for debug

Behaviour:
- Reset: async on rst high. Sync flops reset to 1. FSM goes to IDLE. All outputs are 0, except state_out = IDLE (0).
- Input sync: rx passes through a 2-FF synchronizer (rx_s). All decisions use rx_s.
- FSM encodings: IDLE=0, START=1, DATA=2, STOP=3, DECODE=4, BREAK=5.
- IDLE: when rx_s = 0, go to START and clear the bit counter.
- START: at count CLKS_PER_BIT/2-1, resample rx_s.
  - If rx_s = 1: glitch; return to IDLE with no flags.
  - Otherwise: clear the counter and go to DATA.
- DATA: sample rx_s at every CLKS_PER_BIT-th clock, i.e. the bit centre. Shift in LSB first. After 8 bits, go to STOP.
- STOP: sample at the bit centre.
  - rx_s = 1: go to DECODE.
  - rx_s = 0: pulse frame_err for 1 cycle, discard the frame, go to BREAK.
- BREAK: wait for rx_s = 1, then go to IDLE.
- DECODE (exactly 1 cycle), then IDLE:
  - Codeword c = byte[6:0]. Position k (1..7) = c[k-1]; layout p1,p2,d1,p3,d2,d3,d4.
  - s1 = c0^c2^c4^c6, s2 = c1^c2^c5^c6, s3 = c3^c4^c5^c6; syndrome = {s3,s2,s1}.
  - If syndrome != 0, invert c[syndrome-1].
  - Nibble = {c6,c5,c4,c2}. Pad = byte[7].
- Output register:
  - On DECODE with data_valid = 0: load data_out, syndrome, corrected, pad_err. Assert data_valid the next cycle. Latency is 1 clk after the stop-bit centre sample.
  - On DECODE with data_valid = 1 and no handshake that same cycle: pulse overrun, keep the old data, drop the new frame.
  - If the handshake and DECODE coincide: load the new data and keep data_valid = 1.
- Handshake: data_valid stays high and outputs stay stable until data_valid && data_ready. data_valid drops the next cycle. data_ready while data_valid = 0 is ignored.
- Multi-bit errors: not detected. A 2-bit error miscorrects silently, as Hamming(7,4) intends.
- Back-to-back frames: a start bit immediately after the stop-bit centre is accepted. The half stop bit remaining suffices because the line is already high.
- Reset mid-frame: the partial frame is lost. No flags are raised after reset release.

Decomposition:
- Package uart_hamming_pkg:
  - FSM state enum (3-bit).
  - Localparams: FRAME_BITS=8, CODE_BITS=7.
  - Function hamming74_correct(c[6:0]) returning {syndrome, corrected codeword}. The same package is shared with the encoder for the bit layout.
- One natural sub-module: uart_bit_sampler (synchronizer + baud counter + mid-bit strobe).
- Hamming decode stays a package function, not a module.

Test Plan:
- Nibble 0xB: encoded byte 0x55 sent with CLKS_PER_BIT=16 -> data_valid 1 clk after the stop centre; data_out=0xB, syndrome=0, corrected=0, pad_err=0.
- Byte 0x45 (0x55 with c[4] flipped) -> data_out=0xB, syndrome=5, corrected=1.
- Byte 0xD5 -> data_out=0xB, pad_err=1, syndrome=0.
- Frame with stop bit driven 0, then line held low 40 clks, then a valid 0x55 frame -> one frame_err pulse, no data_valid for the bad frame, state_out=5 until rx high, then data_out=0xB delivered.
- rx low for 4 clks then high -> busy pulses, returns to IDLE, no data_valid, no flags.
- Handshake and reset cases:
  - 0x55 then 0x00 with data_ready=0 -> overrun pulse on the second frame; data_out remains 0xB.
  - Assert data_ready -> data_valid drops next cycle.
  - rst asserted during bit 3 of a frame -> all outputs 0, the next full frame decodes correctly.

Source files
------------

// File: rtl/uart_hamming_pkg.sv
// Shared definitions for the Hamming(7,4) UART link: frame geometry,
// receiver FSM encodings and the single-error-correcting decoder.
package uart_hamming_pkg;

   localparam int FRAME_BITS = 8;
   localparam int CODE_BITS  = 7;

   typedef logic [2:0] rx_state_t;

   localparam rx_state_t ST_IDLE   = 3'd0;
   localparam rx_state_t ST_START  = 3'd1;
   localparam rx_state_t ST_DATA   = 3'd2;
   localparam rx_state_t ST_STOP   = 3'd3;
   localparam rx_state_t ST_DECODE = 3'd4;
   localparam rx_state_t ST_BREAK  = 3'd5;

   typedef struct packed {
      logic [2:0]           syndrome;
      logic [CODE_BITS-1:0] code;
   } ham_fix_t;

   typedef struct packed {
      logic [3:0] data;
      logic [2:0] syndrome;
      logic       corrected;
      logic       pad;
   } rx_word_t;

   // Position k (1..7) of the codeword sits in c[k-1]: p1,p2,d1,p3,d2,d3,d4.
   function automatic ham_fix_t hamming74_correct(input logic [CODE_BITS-1:0] c);
      ham_fix_t r;
      r.syndrome[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
      r.syndrome[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
      r.syndrome[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
      if (r.syndrome != 3'd0) begin
         r.code = c ^ (7'd1 << (r.syndrome - 3'd1));
      end else begin
         r.code = c;
      end
      return r;
   endfunction

   function automatic rx_word_t hamming74_decode(input logic [FRAME_BITS-1:0] frame);
      ham_fix_t fix;
      rx_word_t w;
      fix         = hamming74_correct(frame[CODE_BITS-1:0]);
      w.data      = {fix.code[6], fix.code[5], fix.code[4], fix.code[2]};
      w.syndrome  = fix.syndrome;
      w.corrected = (fix.syndrome != 3'd0);
      w.pad       = frame[FRAME_BITS-1];
      return w;
   endfunction

endpackage

// File: rtl/uart_hamming_rx_sampler.sv
// Line synchronizer plus baud counter; tick_o marks the half-bit point
// during the start bit and the bit centre afterwards.
module uart_bit_sampler #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic rx_i,
   input  logic run_i,
   input  logic half_i,
   output logic rx_s_o,
   output logic tick_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] last_s;
   logic             tick_s;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_i};
      end
   end

   // Strobe target and counter next value.
   always_comb begin
      last_s = FULL_LAST;
      if (half_i) begin
         last_s = HALF_LAST;
      end else begin
         last_s = FULL_LAST;
      end
      tick_s = run_i && (cnt_q == last_s);
      cnt_d  = cnt_q;
      if (!run_i || tick_s) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Baud counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rx_s_o = sync_q[1];
   assign tick_o = tick_s;

endmodule

// File: rtl/uart_hamming_rx.sv
// 8N1 receiver for the Hamming(7,4) UART link: deserializes, corrects single
// bit errors and presents the nibble on a valid/ready interface.
module uart_hamming_rx
   import uart_hamming_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [3:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic [2:0] syndrome,
   output logic       corrected,
   output logic       pad_err,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy,
   output logic [2:0] state_out
);

   localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

   logic       rx_s;
   logic       tick_s;
   logic       run_s;
   logic       half_s;
   rx_word_t   word_s;

   rx_state_t  state_q, state_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic [3:0] data_q, data_d;
   logic [2:0] syn_q, syn_d;
   logic       corr_q, corr_d;
   logic       pad_q, pad_d;
   logic       valid_q, valid_d;
   logic       fe_q, fe_d;
   logic       ov_q, ov_d;
   logic       busy_q, busy_d;

   assign run_s  = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
   assign half_s = (state_q == ST_START);

   uart_bit_sampler #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_sampler (
      .clk    (clk),
      .rst    (rst),
      .rx_i   (rx),
      .run_i  (run_s),
      .half_i (half_s),
      .rx_s_o (rx_s),
      .tick_o (tick_s)
   );

   // Frame FSM next-state logic.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      fe_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bit_d = 3'd0;
            if (!rx_s) begin
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s && rx_s) begin
               state_d = ST_IDLE;
            end else if (tick_s) begin
               state_d = ST_DATA;
               bit_d   = 3'd0;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == LAST_BIT) begin
                  state_d = ST_STOP;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_STOP: begin
            if (tick_s && rx_s) begin
               state_d = ST_DECODE;
            end else if (tick_s) begin
               state_d = ST_BREAK;
               fe_d    = 1'b1;
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_DECODE: begin
            state_d = ST_IDLE;
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BREAK;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Output holding register with valid/ready handshake and overrun detection.
   always_comb begin
      word_s  = hamming74_decode(shift_q);
      data_d  = data_q;
      syn_d   = syn_q;
      corr_d  = corr_q;
      pad_d   = pad_q;
      valid_d = valid_q;
      ov_d    = 1'b0;
      if ((state_q == ST_DECODE) && (!valid_q || data_ready)) begin
         data_d  = word_s.data;
         syn_d   = word_s.syndrome;
         corr_d  = word_s.corrected;
         pad_d   = word_s.pad;
         valid_d = 1'b1;
      end else if (state_q == ST_DECODE) begin
         ov_d    = 1'b1;
      end else if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         data_q  <= 4'd0;
         syn_q   <= 3'd0;
         corr_q  <= 1'b0;
         pad_q   <= 1'b0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         syn_q   <= syn_d;
         corr_q  <= corr_d;
         pad_q   <= pad_d;
         valid_q <= valid_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
         busy_q  <= busy_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign syndrome   = syn_q;
   assign corrected  = corr_q;
   assign pad_err    = pad_q;
   assign frame_err  = fe_q;
   assign overrun    = ov_q;
   assign busy       = busy_q;
   assign state_out  = state_q;

endmodule
